// File: rtl/data_port_arbiter.sv
// Two-requester (core, DMA) arbiter in front of a single-ported data RAM.
// One access per two cycles, with a starvation guard that eventually hands priority to the DMA.
module data_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_adr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [3:0]  dma_be_i,
  input  logic [31:0] dma_adr_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [31:0] dma_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic        owner_dma;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        rvalid_core_q;
  logic        rvalid_dma_q;

  logic gnt_window;
  logic dma_wins;
  logic core_gnt;
  logic dma_gnt;
  logic any_gnt;
  logic sel_we;

  // Grants are gated by reset so nothing is offered while rst_n_i is low.
  always_comb begin
    gnt_window = rst_n_i && (state == IDLE || state == RESP);
    dma_wins   = dma_req_i && (!core_req_i || starve_cnt == LIMIT);
    dma_gnt    = gnt_window && dma_wins;
    core_gnt   = gnt_window && core_req_i && !dma_wins;
    any_gnt    = core_gnt || dma_gnt;
    sel_we     = dma_wins ? dma_we_i : core_we_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      owner_dma     <= 1'b0;
      we_q          <= 1'b0;
      be_q          <= '0;
      adr_q         <= '0;
      wdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      rvalid_core_q <= 1'b0;
      rvalid_dma_q  <= 1'b0;
    end else begin
      mem_req_q     <= any_gnt;
      mem_we_q      <= any_gnt && sel_we;
      rvalid_core_q <= (state == ISSUE) && !owner_dma;
      rvalid_dma_q  <= (state == ISSUE) && owner_dma;

      if (any_gnt) begin
        owner_dma <= dma_gnt;
        we_q      <= sel_we;
        be_q      <= dma_gnt ? dma_be_i    : core_be_i;
        adr_q     <= dma_gnt ? dma_adr_i   : core_adr_i;
        wdata_q   <= dma_gnt ? dma_wdata_i : core_wdata_i;
      end

      if (gnt_window) begin
        if (dma_gnt || !dma_req_i)
          starve_cnt <= '0;
        else if (starve_cnt != LIMIT)
          starve_cnt <= starve_cnt + 4'd1;
      end

      case (state)
        IDLE:    if (any_gnt) state <= ISSUE;
        ISSUE:   state <= RESP;
        RESP:    state <= any_gnt ? ISSUE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign core_gnt_o    = core_gnt;
  assign dma_gnt_o     = dma_gnt;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = be_q;
  assign mem_adr_o     = adr_q;
  assign mem_wdata_o   = wdata_q;
  assign core_rvalid_o = rvalid_core_q;
  assign dma_rvalid_o  = rvalid_dma_q;

  // RAM data arrives in RESP; we_q still describes the current owner then.
  assign core_rdata_o  = (rvalid_core_q && !we_q) ? mem_rdata_i : '0;
  assign dma_rdata_o   = (rvalid_dma_q  && !we_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed, table-driven bench for data_port_arbiter with a small behavioural RAM.
module tb_data_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, dma_req, dma_we;
  logic [3:0]  core_be, dma_be;
  logic [31:0] core_adr, core_wdata, dma_adr, dma_wdata;
  logic        core_gnt, core_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] core_rdata, dma_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:63];

  always #5 clk = ~clk;

  data_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
    .core_adr_i(core_adr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_be_i(dma_be),
    .dma_adr_i(dma_adr), .dma_wdata_i(dma_wdata),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_adr_o(mem_adr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // RAM registers read data on the edge that samples mem_req.
  always @(posedge clk) begin
    if (mem_req) begin
      mem_rdata <= ram[mem_adr[7:2]];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_adr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " core_gnt"},    {31'b0, core_gnt},    32'h0);
    chk({tag, " dma_gnt"},     {31'b0, dma_gnt},     32'h0);
    chk({tag, " core_rvalid"}, {31'b0, core_rvalid}, 32'h0);
    chk({tag, " dma_rvalid"},  {31'b0, dma_rvalid},  32'h0);
    chk({tag, " mem_req"},     {31'b0, mem_req},     32'h0);
  endtask

  task automatic drive_none();
    core_req = 0; core_we = 0; core_be = 4'h0; core_adr = '0; core_wdata = '0;
    dma_req  = 0; dma_we  = 0; dma_be  = 4'h0; dma_adr  = '0; dma_wdata  = '0;
  endtask

  typedef struct {
    logic        dma;
    logic        we;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[0] = 32'h11111111;
    ram[4] = 32'hDEADBEEF;
    ram[8] = 32'h12345678;
    mem_rdata = '0;

    //           dma we  be      adr      wdata          exp_rdata
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h20, 32'h0000ABCD, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 4'hF, 32'h20, 32'h0,        32'h1234ABCD};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 4'hF, 32'h04, 32'hCAFEF00D, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h04, 32'h0,        32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b1, 4'h8, 32'h10, 32'hAA000000, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 4'hF, 32'h10, 32'h0,        32'hAAADBEEF};

    // Reset: requests asserted but nothing may be granted, all outputs zero.
    rst_n = 0;
    drive_none();
    core_req = 1; dma_req = 1;
    @(negedge clk); #1;
    chk_idle_outputs("reset");
    chk("reset mem_we",    {31'b0, mem_we}, 32'h0);
    chk("reset mem_be",    {28'b0, mem_be}, 32'h0);
    chk("reset mem_adr",   mem_adr,    32'h0);
    chk("reset mem_wdata", mem_wdata,  32'h0);
    chk("reset core_rdata", core_rdata, 32'h0);
    chk("reset dma_rdata",  dma_rdata,  32'h0);
    drive_none();
    @(negedge clk);
    rst_n = 1;

    // Single transactions from the table.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      if (vecs[v].dma) begin
        dma_req = 1; dma_we = vecs[v].we; dma_be = vecs[v].be;
        dma_adr = vecs[v].adr; dma_wdata = vecs[v].wdata;
      end else begin
        core_req = 1; core_we = vecs[v].we; core_be = vecs[v].be;
        core_adr = vecs[v].adr; core_wdata = vecs[v].wdata;
      end
      #1;
      chk($sformatf("v%0d core_gnt", v), {31'b0, core_gnt}, {31'b0, !vecs[v].dma});
      chk($sformatf("v%0d dma_gnt", v),  {31'b0, dma_gnt},  {31'b0, vecs[v].dma});
      chk($sformatf("v%0d mem_req c0", v), {31'b0, mem_req}, 32'h0);
      @(negedge clk);
      drive_none();
      #1;
      chk($sformatf("v%0d mem_req", v),   {31'b0, mem_req}, 32'h1);
      chk($sformatf("v%0d mem_we", v),    {31'b0, mem_we},  {31'b0, vecs[v].we});
      chk($sformatf("v%0d mem_be", v),    {28'b0, mem_be},  {28'b0, vecs[v].be});
      chk($sformatf("v%0d mem_adr", v),   mem_adr,   vecs[v].adr);
      chk($sformatf("v%0d mem_wdata", v), mem_wdata, vecs[v].wdata);
      chk($sformatf("v%0d rvalid c1", v), {30'b0, core_rvalid, dma_rvalid}, 32'h0);
      @(negedge clk); #1;
      chk($sformatf("v%0d core_rvalid", v), {31'b0, core_rvalid}, {31'b0, !vecs[v].dma});
      chk($sformatf("v%0d dma_rvalid", v),  {31'b0, dma_rvalid},  {31'b0, vecs[v].dma});
      chk($sformatf("v%0d core_rdata", v), core_rdata, vecs[v].dma ? 32'h0 : vecs[v].exp_rdata);
      chk($sformatf("v%0d dma_rdata", v),  dma_rdata,  vecs[v].dma ? vecs[v].exp_rdata : 32'h0);
      chk($sformatf("v%0d mem_req c2", v), {31'b0, mem_req}, 32'h0);
      chk($sformatf("v%0d mem_adr hold", v), mem_adr, vecs[v].adr);
    end

    // Starvation: both request continuously; DMA wins the 5th and 10th arbitration.
    @(negedge clk);
    core_req = 1; core_adr = 32'h0; dma_req = 1; dma_adr = 32'h0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("starve%0d core_gnt", k), {31'b0, core_gnt}, {31'b0, !(k == 4 || k == 9)});
      chk($sformatf("starve%0d dma_gnt", k),  {31'b0, dma_gnt},  {31'b0, (k == 4 || k == 9)});
      @(negedge clk); #1;
      chk($sformatf("starve%0d issue gnt", k), {30'b0, core_gnt, dma_gnt}, 32'h0);
      @(negedge clk);
    end
    drive_none();
    @(negedge clk); @(negedge clk);

    // Back-to-back core reads of 0x0 and 0x4 with req held high.
    @(negedge clk);
    core_req = 1; core_adr = 32'h0;
    #1; chk("b2b c0 gnt", {31'b0, core_gnt}, 32'h1);
    @(negedge clk);
    core_adr = 32'h4;
    #1; chk("b2b c1 mem_req", {31'b0, mem_req}, 32'h1);
    chk("b2b c1 mem_adr", mem_adr, 32'h0);
    chk("b2b c1 gnt", {31'b0, core_gnt}, 32'h0);
    @(negedge clk); #1;
    chk("b2b c2 gnt", {31'b0, core_gnt}, 32'h1);
    chk("b2b c2 rvalid", {31'b0, core_rvalid}, 32'h1);
    chk("b2b c2 rdata", core_rdata, 32'h11111111);
    chk("b2b c2 mem_req", {31'b0, mem_req}, 32'h0);
    @(negedge clk);
    drive_none();
    #1; chk("b2b c3 mem_req", {31'b0, mem_req}, 32'h1);
    chk("b2b c3 mem_adr", mem_adr, 32'h4);
    chk("b2b c3 rvalid", {31'b0, core_rvalid}, 32'h0);
    @(negedge clk); #1;
    chk("b2b c4 rvalid", {31'b0, core_rvalid}, 32'h1);
    chk("b2b c4 rdata", core_rdata, 32'hCAFEF00D);
    chk("b2b c4 mem_req", {31'b0, mem_req}, 32'h0);
    chk("b2b c4 gnt", {31'b0, core_gnt}, 32'h0);
    @(negedge clk); #1;
    chk_idle_outputs("b2b c5");

    // Reset pulse during ISSUE aborts the read; first cycle after release grants.
    @(negedge clk);
    core_req = 1; core_adr = 32'h10;
    #1; chk("rst c0 gnt", {31'b0, core_gnt}, 32'h1);
    @(negedge clk);
    drive_none();
    #1; chk("rst c1 mem_req", {31'b0, mem_req}, 32'h1);
    #1 rst_n = 0;
    #1; chk("rst in mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst in mem_adr", mem_adr, 32'h0);
    @(negedge clk);
    core_req = 1; core_adr = 32'h4;
    #1; chk_idle_outputs("rst held");
    rst_n = 1;
    #1; chk("rst rel gnt", {31'b0, core_gnt}, 32'h1);
    chk("rst rel rvalid", {30'b0, core_rvalid, dma_rvalid}, 32'h0);
    @(negedge clk);
    drive_none();
    #1; chk("rst rel mem_req", {31'b0, mem_req}, 32'h1);
    chk("rst rel mem_adr", mem_adr, 32'h4);
    @(negedge clk); #1;
    chk("rst rel rvalid2", {31'b0, core_rvalid}, 32'h1);
    chk("rst rel rdata", core_rdata, 32'hCAFEF00D);

    // Idle: nothing requested for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk_idle_outputs($sformatf("idle%0d", c));
    end
    @(negedge clk);
    dma_req = 1; dma_adr = 32'h10;
    #1; chk("idle exit dma_gnt", {31'b0, dma_gnt}, 32'h1);
    @(negedge clk);
    drive_none();
    @(negedge clk); #1;
    chk("idle exit rdata", dma_rdata, 32'hAAADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if (core_gnt && dma_gnt) begin
      errors++;
      $display("FAIL both_gnt: got 1 expected 0");
    end
  end

endmodule

// File: doc/data_port_arbiter.md
DATA_PORT_ARBITER -- requirements
Module: data_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost arbitrations after which the DMA requester takes priority; legal range 1..15.
REQ-002 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-003 clk_i  in  1  rising-edge clock.
REQ-004 rst_n_i  in  1  asynchronous active-low reset.
REQ-005 core_req_i / core_we_i  in  1/1  core access request / write enable.
REQ-006 core_be_i / core_adr_i / core_wdata_i  in  4/32/32  core byte enables, byte address, write data.
REQ-007 core_gnt_o  out  1  core request accepted this cycle.
REQ-008 core_rvalid_o / core_rdata_o  out  1/32  core access complete / read data.
REQ-009 dma_req_i, dma_we_i, dma_be_i, dma_adr_i, dma_wdata_i, dma_gnt_o, dma_rvalid_o, dma_rdata_o: same widths and meaning as the core_* set.
REQ-010 mem_req_o / mem_we_o  out  1/1  data-port request / write enable to the RAM.
REQ-011 mem_be_o / mem_adr_o / mem_wdata_o  out  4/32/32  byte enables, address, write data to the RAM.
REQ-012 mem_rdata_i  in  32  RAM read data, registered by the RAM on the edge that samples mem_req_o.

Function
REQ-013 FSM states: IDLE, ISSUE, RESP; IDLE->ISSUE on any grant; ISSUE->RESP always; RESP->ISSUE on grant, else RESP->IDLE.
REQ-014 Grants SHALL be combinational and issued only in IDLE or RESP; core_gnt_o and dma_gnt_o SHALL never be high together.
REQ-015 Arbitration: core wins when both request, unless starve_cnt == STARVE_LIMIT, in which case DMA wins.
REQ-016 starve_cnt (4 bit) SHALL increment, saturating at STARVE_LIMIT, each grant cycle in which dma_req_i=1 and DMA loses; SHALL clear when DMA is granted or dma_req_i=0.
REQ-017 On grant at edge N the winner's we/be/adr/wdata and owner ID SHALL be latched; in the following cycle (ISSUE) mem_req_o=1 with the latched fields for exactly one cycle.
REQ-018 mem_be_o, mem_adr_o, mem_wdata_o SHALL be forwarded unmodified; outside ISSUE mem_req_o=0, mem_we_o=0 and the other mem_* outputs hold their last values.
REQ-019 In RESP exactly the owner's rvalid_o SHALL be 1 for one cycle; latency grant-cycle -> rvalid = 2 cycles; throughput one access per 2 cycles.
REQ-020 Owner rdata_o SHALL equal mem_rdata_i for reads and 32'h0 for writes during its rvalid cycle, and 32'h0 otherwise.
REQ-021 The non-owner's rvalid_o SHALL be 0; a new grant in RESP SHALL NOT suppress the current response.
REQ-022 Requester inputs SHALL be ignored outside grant-capable states; requesters hold req until gnt.

Reset
REQ-023 While rst_n_i=0: state=IDLE, starve_cnt=0, all gnt/rvalid/mem_req/mem_we outputs 0, all data/address outputs 32'h0 and mem_be_o=4'h0.
REQ-024 Reset asserted mid-transaction SHALL abort it without any rvalid; the first grant after release is possible in the first cycle with rst_n_i=1.

Verification
REQ-025 Core read: core_req_i=1, core_we_i=0, adr=0x10; RAM word 4 = 0xDEADBEEF -> core_gnt_o cycle 0, mem_req_o/mem_adr_o=0x10 cycle 1, core_rvalid_o=1 and core_rdata_o=0xDEADBEEF cycle 2.
REQ-026 DMA write: dma_we_i=1, be=4'b0011, adr=0x20, wdata=0x0000ABCD -> mem_we_o=1, mem_be_o=4'b0011 cycle 1; dma_rvalid_o=1, dma_rdata_o=0 cycle 2; subsequent read of 0x20 returns 0xABCD in low half.
REQ-027 Simultaneous requests, STARVE_LIMIT=4, core requests continuously -> core granted 4 times, DMA granted on the 5th arbitration, starve_cnt then 0.
REQ-028 Back-to-back: core reads at 0x0 and 0x4 held high -> grants in cycles 0 and 2, rvalid in cycles 2 and 4, mem_req_o high in cycles 1 and 3 only.
REQ-029 Reset pulse during ISSUE -> no rvalid on either side, mem_req_o=0 within reset, normal grant in the first cycle after release.
REQ-030 Idle: no requests for 10 cycles -> all gnt, rvalid, mem_req_o remain 0 and state stays IDLE.
